// File: rtl/bcd_arb_pkg.sv
// bcd_arb_pkg: shared widths and FSM state encodings for the BCD converter arbiter
package bcd_arb_pkg;
  localparam int BIN_W = 12;
  localparam int BCD_W = 16;
  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_e;
endpackage

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting just after the last granted channel
module rr_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] winner_o,
  output logic          any_req_o
);
  function automatic logic [PW-1:0] wrap(input int s);
    return PW'(s >= N ? s - N : s);
  endfunction
  always_comb begin
    winner_o = '0;
    for (int k = N; k >= 1; k--)
      if (req_i[wrap(int'(ptr_i) + k)]) winner_o = wrap(int'(ptr_i) + k);
    any_req_o = |req_i;
  end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin sharing of one serial binary-to-BCD converter among N requesters
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int TIMEOUT = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*BIN_W-1:0]   bin_flat,
  output logic [N-1:0]         ack,
  output logic [N*BCD_W-1:0]   bcd_flat,
  output logic [N-1:0]         valid,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 conv_en,
  output logic [BIN_W-1:0]     conv_bin,
  input  logic [BCD_W-1:0]     conv_bcd,
  input  logic                 conv_rdy
);
  localparam int PW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT) + 1;
  state_e           state_q;
  logic [PW-1:0]    ptr_q, win_q, pick;
  logic             any;
  logic [TW-1:0]    timer_q;
  logic [N-1:0]     ack_q, valid_q;
  logic [BCD_W-1:0] bcd_q [N];
  logic             conv_en_q, err_q;
  logic [BIN_W-1:0] conv_bin_q;
  rr_pick #(.N(N)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick),
    .any_req_o(any)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_DRAIN;
      ptr_q      <= PW'(N - 1);
      win_q      <= '0;
      timer_q    <= '0;
      ack_q      <= '0;
      valid_q    <= '0;
      bcd_q      <= '{default: '0};
      conv_en_q  <= 1'b0;
      conv_bin_q <= '0;
      err_q      <= 1'b0;
    end else begin
      ack_q     <= '0;
      conv_en_q <= 1'b0;
      case (state_q)
        S_DRAIN: begin
          timer_q <= timer_q + 1'b1;
          if (timer_q == TW'(TIMEOUT - 1)) state_q <= S_IDLE;
        end
        S_IDLE: if (any) begin
          state_q        <= S_ISSUE;
          win_q          <= pick;
          ptr_q          <= pick;
          timer_q        <= '0;
          ack_q[pick]    <= 1'b1;
          valid_q[pick]  <= 1'b0;
          conv_en_q      <= 1'b1;
          conv_bin_q     <= bin_flat[pick*BIN_W +: BIN_W];
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (conv_rdy) begin
            bcd_q[win_q]   <= conv_bcd;
            valid_q[win_q] <= 1'b1;
            state_q        <= S_GAP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_GAP;
          end else timer_q <= timer_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign ack         = ack_q;
  assign valid       = valid_q;
  assign busy        = state_q != S_IDLE;
  assign timeout_err = err_q;
  assign conv_en     = conv_en_q;
  assign conv_bin    = conv_bin_q;
  for (genvar g = 0; g < N; g++) begin : g_bcd
    assign bcd_flat[g*BCD_W +: BCD_W] = bcd_q[g];
  end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: random and directed scoreboard bench with a behavioural converter
module tb_bcd_conv_arbiter;
  localparam int N = 4;
  localparam int TIMEOUT = 128;
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0, ack, valid;
  logic [N*12-1:0] bin_flat = '0;
  logic [N*16-1:0] bcd_flat;
  logic busy, timeout_err, conv_en, conv_rdy;
  logic [11:0] conv_bin;
  logic [15:0] conv_bcd;
  logic hold = 0, mute = 0, spur = 0;
  always #5 clk = ~clk;
  bcd_conv_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .bin_flat(bin_flat), .ack(ack),
    .bcd_flat(bcd_flat), .valid(valid), .busy(busy), .timeout_err(timeout_err),
    .conv_en(conv_en), .conv_bin(conv_bin), .conv_bcd(conv_bcd), .conv_rdy(conv_rdy)
  );
  function automatic logic [15:0] to_bcd(input logic [11:0] b);
    int v;
    v = int'(b);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  logic m_busy = 0, m_rdy = 0;
  int m_cnt = 0, lat_lo = 4, lat_hi = 60;
  logic [11:0] m_bin = '0;
  logic [15:0] m_bcd = '0;
  always @(posedge clk) begin
    m_rdy <= 1'b0;
    if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        m_rdy  <= !mute;
        m_bcd  <= to_bcd(m_bin);
      end else m_cnt <= m_cnt - 1;
    end else if (conv_en) begin
      m_busy <= 1'b1;
      m_cnt  <= int'($urandom_range(lat_hi, lat_lo));
      m_bin  <= conv_bin;
    end
  end
  assign conv_rdy = m_rdy | spur;
  assign conv_bcd = m_bcd;
  int vecs = 0, errs = 0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  typedef struct {int ch; logic [15:0] bcd; bit to;} exp_t;
  exp_t q[$];
  exp_t x;
  logic [N-1:0] req_e, e_valid, v_p, oh;
  logic [N*12-1:0] bin_e;
  logic [15:0] e_bcd [N];
  logic err_p;
  int m_ptr, mw, cyc = 0, last_v = -100, en_cyc = 0, en_cnt = 0, done_cnt = 0;
  function automatic logic [63:0] flat();
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[i*16 +: 16] = e_bcd[i];
    return f;
  endfunction
  always @(posedge clk) begin
    req_e <= req;
    bin_e <= bin_flat;
  end
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_ptr = N - 1;
      e_valid = '0;
      for (int i = 0; i < N; i++) e_bcd[i] = '0;
      v_p = '0;
      err_p = 1'b0;
      last_v = -100;
    end else begin
      if (conv_en || ack != '0) begin
        en_cnt++;
        mw = -1;
        for (int k = 1; k <= N; k++)
          if (req_e[(m_ptr + k) % N]) begin
            mw = (m_ptr + k) % N;
            break;
          end
        chk("grant_had_req", 64'(req_e != '0), 1);
        if (mw >= 0) begin
          oh = '0;
          oh[mw] = 1'b1;
          chk("grant_ack_en", {conv_en, ack}, {1'b1, oh});
          chk("grant_conv_bin", conv_bin, bin_e[mw*12 +: 12]);
          chk("grant_gap", 64'(cyc - last_v >= 2), 1);
          q.push_back('{mw, to_bcd(bin_e[mw*12 +: 12]), mute});
          m_ptr = mw;
          e_valid[mw] = 1'b0;
          en_cyc = cyc;
        end
      end
      for (int c = 0; c < N; c++)
        if (valid[c] && !v_p[c]) begin
          last_v = cyc;
          done_cnt++;
          if (q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_valid: ch %0d rose with nothing outstanding", c);
          end else begin
            x = q.pop_front();
            chk("result_ch", c, x.ch);
            chk("result_not_timeout", x.to, 0);
            chk("result_bcd", bcd_flat[c*16 +: 16], x.bcd);
            e_bcd[x.ch] = x.bcd;
            e_valid[x.ch] = 1'b1;
          end
        end
      if (timeout_err && !err_p) begin
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_timeout: nothing outstanding");
        end else begin
          x = q.pop_front();
          chk("timeout_expected", x.to, 1);
          chk("timeout_cycles", cyc - en_cyc, TIMEOUT + 1);
        end
      end
      chk("valid_all", valid, e_valid);
      chk("bcd_all", bcd_flat, flat());
      v_p = valid;
      err_p = timeout_err;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (!hold) req = req & ~ack;
  endtask
  task automatic set_bin(input int c, input int v);
    bin_flat[c*12 +: 12] = 12'(v);
  endtask
  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((q.size() != 0 || busy || req != '0) && n < bound) begin
      tick();
      n++;
    end
    chk("idle_reached", 64'(n < bound), 1);
  endtask
  task automatic wait_en(input int bound);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!conv_en && n < bound);
    chk("conv_en_seen", conv_en, 1);
  endtask
  task automatic reset_checks();
    chk("rst_ack", ack, 0);
    chk("rst_valid", valid, 0);
    chk("rst_bcd", bcd_flat, 0);
    chk("rst_conv_en", conv_en, 0);
    chk("rst_conv_bin", conv_bin, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_busy", busy, 1);
  endtask
  initial begin
    int n, base;
    repeat (3) tick();
    reset_checks();
    rst = 0;
    tick();
    chk("drain_busy", busy, 1);
    repeat (TIMEOUT + 2) tick();
    chk("drain_done", busy, 0);
    base = en_cnt;
    set_bin(0, 4095);
    req = 4'b0001;
    wait_idle(300);
    chk("t1_en_count", en_cnt - base, 1);
    chk("t1_valid0", valid[0], 1);
    chk("t1_bcd0", bcd_flat[15:0], 16'h4095);
    set_bin(0, 1); set_bin(1, 22); set_bin(2, 333); set_bin(3, 4000);
    base = done_cnt;
    hold = 1;
    req = 4'hF;
    n = 0;
    while (done_cnt - base < 5 && n < 1000) begin tick(); n++; end
    chk("t2_progress", 64'(done_cnt - base >= 5), 1);
    hold = 0;
    req = '0;
    wait_idle(300);
    chk("t2_bcd", bcd_flat, 64'h4000_0333_0022_0001);
    req = 4'b0001;
    wait_idle(300);
    req = 4'b0110;
    wait_en(300);
    chk("t3_first", ack, 4'b0010);
    wait_en(300);
    chk("t3_second", ack, 4'b0100);
    wait_idle(300);
    mute = 1;
    req = 4'b1000;
    n = 0;
    while (!timeout_err && n < 500) begin tick(); n++; end
    chk("t4_err", timeout_err, 1);
    chk("t4_valid3", valid[3], 0);
    wait_idle(300);
    mute = 0;
    repeat (70) tick();
    req = 4'b1000;
    wait_idle(300);
    chk("t4_served", valid[3], 1);
    chk("t4_err_sticky", timeout_err, 1);
    lat_lo = 40;
    lat_hi = 40;
    set_bin(1, 1234);
    req = 4'b0010;
    wait_en(300);
    repeat (10) tick();
    rst = 1;
    repeat (2) tick();
    reset_checks();
    rst = 0;
    repeat (TIMEOUT + 2) tick();
    chk("t5_valid", valid, 0);
    chk("t5_bcd", bcd_flat, 0);
    chk("t5_busy", busy, 0);
    lat_lo = 4;
    lat_hi = 60;
    req = 4'b0010;
    wait_idle(300);
    chk("t5_bcd1", bcd_flat[31:16], 16'h1234);
    chk("t5_valid1", valid[1], 1);
    spur = 1;
    tick();
    spur = 0;
    repeat (3) tick();
    chk("t6_valid_quiet", valid, e_valid);
    chk("t6_bcd_quiet", bcd_flat, flat());
    set_bin(2, 0);
    req = 4'b0100;
    wait_idle(300);
    chk("t6_bcd2", bcd_flat[47:32], 16'h0000);
    chk("t6_valid2", valid[2], 1);
    for (int it = 0; it < 40; it++) begin
      hold = 1'($urandom_range(1, 0));
      for (int c = 0; c < N; c++) set_bin(c, int'($urandom_range(4095, 0)));
      req = req | 4'($urandom_range(15, 0));
      repeat ($urandom_range(60, 0)) tick();
    end
    hold = 0;
    req = '0;
    wait_idle(400);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
